// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared constants for the UART receive buffer (status word
//               bit positions).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  // Bit positions inside the UART_Rx_Status word
  localparam int ST_NEMPTY  = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_CNT_LSB = 3;

endpackage : uart_rx_pkg

`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
// ============================================================================
// Module      : uart_rx_fifo_mem
// Description : First-word-fall-through FIFO storage with read/write
//               pointers, occupancy count and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo_mem #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              do_pop;
  logic              do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clr_i;

  // Next occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array; contents are not reset because empty masks them
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally; reset and flush return everything to zero
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : uart_rx_fifo_mem

`default_nettype wire

// File: rtl/uart_rx_buffer.sv
// ============================================================================
// Module      : uart_rx_buffer
// Description : UART receive buffer: FWFT FIFO, status word, sticky overrun
//               flag and registered threshold interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_buffer
  import uart_rx_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              ovr_clr,
  input  logic              irq_en,
  output logic [WIDTH-1:0]  UART_Rx_Reg,
  output logic [WIDTH-1:0]  UART_Rx_Status,
  output logic              irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              ovr_q;
  logic              ovr_d;
  logic              ovr_set;
  logic              irq_q;

  uart_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (rx_valid),
    .pop_i   (rd_en),
    .wdata_i (rx_data),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // A character is lost only when full with no pop to make room; a flush
  // drops the character silently instead.
  assign ovr_set = rx_valid & full & ~rd_en & ~flush;

  // Sticky overrun: a new overrun beats a simultaneous clear
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // Overrun flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  // Threshold interrupt, registered from the current occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en & (count >= CW'(THRESH));
    end
  end

  assign irq = irq_q;

  // Head character zero-extended to the bus width, zero when empty
  always_comb begin
    UART_Rx_Reg = '0;
    if (!empty) begin
      UART_Rx_Reg[DATA_W-1:0] = head;
    end
  end

  // Status word packing
  always_comb begin
    UART_Rx_Status                  = '0;
    UART_Rx_Status[ST_NEMPTY]       = ~empty;
    UART_Rx_Status[ST_FULL]         = full;
    UART_Rx_Status[ST_OVR]          = ovr_q;
    UART_Rx_Status[ST_CNT_LSB +: CW] = count;
  end

endmodule : uart_rx_buffer

`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
// ============================================================================
// Module      : tb_uart_rx_buffer
// Description : Self-checking bench for uart_rx_buffer using a queue-based
//               reference model with directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_buffer;

  localparam int WIDTH  = 32;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int THRESH = 4;

  logic              clk;
  logic              rst;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rd_en;
  logic              flush;
  logic              ovr_clr;
  logic              irq_en;
  logic [WIDTH-1:0]  UART_Rx_Reg;
  logic [WIDTH-1:0]  UART_Rx_Status;
  logic              irq;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] m_q [$];
  bit                m_ovr;
  bit                m_irq;

  uart_rx_buffer #(
    .WIDTH  (WIDTH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .THRESH (THRESH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rd_en          (rd_en),
    .flush          (flush),
    .ovr_clr        (ovr_clr),
    .irq_en         (irq_en),
    .UART_Rx_Reg    (UART_Rx_Reg),
    .UART_Rx_Status (UART_Rx_Status),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_reg();
    if (m_q.size() == 0) return 32'h0;
    return {24'h0, m_q[0]};
  endfunction

  function automatic logic [31:0] exp_status();
    int n = m_q.size();
    return (32'(n) << 3) | (m_ovr ? 32'h4 : 32'h0) |
           ((n == DEPTH) ? 32'h2 : 32'h0) | ((n != 0) ? 32'h1 : 32'h0);
  endfunction

  // Advance the model by one clock from the behavioural rules
  task automatic model_step(input bit r, input bit v, input logic [7:0] d,
                            input bit rd, input bit fl, input bit oc, input bit ie);
    int  n;
    bit  pop_ok;
    if (r) begin
      m_q.delete();
      m_ovr = 0;
      m_irq = 0;
      return;
    end
    n     = m_q.size();
    m_irq = ie && (n >= THRESH);
    if (fl) begin
      m_q.delete();
      if (oc) m_ovr = 0;
      return;
    end
    pop_ok = rd && (n > 0);
    if (pop_ok) void'(m_q.pop_front());
    if (v) begin
      if (n < DEPTH || pop_ok) m_q.push_back(d);
    end
    if (v && n == DEPTH && !pop_ok) m_ovr = 1;
    else if (oc) m_ovr = 0;
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model
  task automatic step(input bit r, input bit v, input logic [7:0] d,
                      input bit rd, input bit fl, input bit oc, input bit ie);
    rst      = r;
    rx_valid = v;
    rx_data  = d;
    rd_en    = rd;
    flush    = fl;
    ovr_clr  = oc;
    irq_en   = ie;
    @(posedge clk);
    model_step(r, v, d, rd, fl, oc, ie);
    #1;
    chk("rx_reg", UART_Rx_Reg, exp_reg());
    chk("status", UART_Rx_Status, exp_status());
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic push(input logic [7:0] d, input bit ie);
    step(0, 1, d, 0, 0, 0, ie);
  endtask

  task automatic pop(input bit ie);
    step(0, 0, 8'h00, 1, 0, 0, ie);
  endtask

  initial begin
    rst = 1; rx_valid = 0; rx_data = 0; rd_en = 0;
    flush = 0; ovr_clr = 0; irq_en = 0;

    // Reset then idle, including a pop on an empty buffer
    step(1, 0, 8'h00, 0, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0, 0);
    chk("rst_reg", UART_Rx_Reg, 32'h0);
    chk("rst_status", UART_Rx_Status, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    pop(0);
    chk("empty_pop_status", UART_Rx_Status, 32'h0);

    // Three characters in, three out
    push(8'h41, 0); push(8'h42, 0); push(8'h43, 0);
    chk("cnt3_status", UART_Rx_Status, 32'h19);
    chk("cnt3_head", UART_Rx_Reg, 32'h41);
    pop(0); chk("pop1", UART_Rx_Reg, 32'h42);
    pop(0); chk("pop2", UART_Rx_Reg, 32'h43);
    pop(0); chk("pop3", UART_Rx_Reg, 32'h0);
    chk("drained_status", UART_Rx_Status, 32'h0);

    // Overfill: ninth byte lost, overrun set
    for (int i = 0; i < 9; i++) push(8'(i), 0);
    chk("ovr_status", UART_Rx_Status, 32'h47);
    chk("ovr_head", UART_Rx_Reg, 32'h00);
    // Overrun set beats a clear in the same cycle
    step(0, 1, 8'hEE, 0, 0, 1, 0);
    chk("ovr_set_wins", UART_Rx_Status, 32'h47);
    for (int i = 0; i < 8; i++) begin
      chk("ovr_pop_data", UART_Rx_Reg, 32'(i));
      pop(0);
    end
    step(0, 0, 8'h00, 0, 0, 1, 0);
    chk("ovr_clr", UART_Rx_Status, 32'h0);

    // Full, push + pop in the same cycle: no overrun, count stays 8
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 0);
    step(0, 1, 8'h55, 1, 0, 0, 0);
    chk("full_pushpop", UART_Rx_Status, 32'h43);
    for (int i = 0; i < 7; i++) pop(0);
    chk("full_pushpop_head", UART_Rx_Reg, 32'h55);
    pop(0);

    // Threshold interrupt
    push(8'h01, 1); push(8'h02, 1); push(8'h03, 1);
    step(0, 0, 8'h00, 0, 0, 0, 1);
    chk("irq_below", {31'h0, irq}, 32'h0);
    push(8'h04, 1);
    chk("irq_pre", {31'h0, irq}, 32'h0);
    step(0, 0, 8'h00, 0, 0, 0, 1);
    chk("irq_set", {31'h0, irq}, 32'h1);
    pop(1);
    step(0, 0, 8'h00, 0, 0, 0, 1);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    // Flush with a simultaneous push: character dropped, overrun untouched
    step(0, 1, 8'h99, 0, 1, 0, 1);
    chk("flush_status", UART_Rx_Status, 32'h0);
    chk("flush_reg", UART_Rx_Reg, 32'h0);

    // Empty push + pop: push happens, pop ignored
    step(0, 1, 8'h77, 1, 0, 0, 0);
    chk("empty_pushpop", UART_Rx_Status, 32'h9);
    pop(0);

    // Wrap-around with interleaved pairs, then reset mid-stream
    push(8'h80, 0);
    for (int i = 1; i <= 20; i++) step(0, 1, 8'h80 + 8'(i), 1, 0, 0, 0);
    chk("wrap_head", UART_Rx_Reg, 32'h94);
    push(8'hA0, 1); push(8'hA1, 1); push(8'hA2, 1); push(8'hA3, 1);
    step(0, 0, 8'h00, 0, 0, 0, 1);
    step(1, 1, 8'h5A, 1, 0, 0, 1);
    chk("midrst_reg", UART_Rx_Reg, 32'h0);
    chk("midrst_status", UART_Rx_Status, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 55),
           8'($urandom),
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 85));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_buffer

`default_nettype wire
